// File: rtl/async_fifo_wr_ctrl_if.sv
// Producer / read-pointer / sram-write bundle for the async FIFO write controller.
//   master : producer side drives wr_req, wr_data and the read-domain Gray pointer.
//            It observes the sram port, wr_gptr and the status flags.
//   slave  : the write controller.
interface async_fifo_wr_ctrl_if #(
   parameter int unsigned ADDR  = 4,
   parameter int unsigned WIDTH = 32
);
   logic             wr_req;
   logic [WIDTH-1:0] wr_data;
   logic [ADDR:0]    rd_gptr;
   logic [ADDR-1:0]  sram_addr;
   logic [WIDTH-1:0] sram_data;
   logic             sram_we;
   logic [ADDR:0]    wr_gptr;
   logic             full;
   logic             almost_full;
   logic [ADDR:0]    wr_level;
   logic             overflow;

   modport master (
      output wr_req, wr_data, rd_gptr,
      input  sram_addr, sram_data, sram_we, wr_gptr, full, almost_full, wr_level, overflow
   );

   modport slave (
      input  wr_req, wr_data, rd_gptr,
      output sram_addr, sram_data, sram_we, wr_gptr, full, almost_full, wr_level, overflow
   );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the SRAM-based async FIFO.
// Accepts producer writes and drives the sram write port combinationally.
// It keeps binary and Gray write pointers and synchronises the read Gray pointer
// through two flops. It registers full, almost_full, wr_level and overflow.
//   clk, rst_n : write clock, async active-low reset
//   bus.slave  : wr_req/wr_data/rd_gptr in; sram_addr/sram_data/sram_we,
//                wr_gptr, full, almost_full, wr_level, overflow out
module async_fifo_wr_ctrl #(
   parameter int unsigned ADDR      = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned AF_THRESH = 12
) (
   input logic                 clk,
   input logic                 rst_n,
   async_fifo_wr_ctrl_if.slave bus
);
   localparam int unsigned PW = ADDR + 1;
   localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wg_q, wg_d;
   logic [PW-1:0] rq1_q, rq2_q;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] lvl_q, lvl_d;
   logic [PW-1:0] full_cmp;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic          ovf_q, ovf_d;
   logic          accept;

   // Gating with rst_n keeps sram_we low for the whole reset assertion.
   assign accept = bus.wr_req & ~full_q & rst_n;

   // The sram captures the word on the same edge that advances the pointer.
   assign bus.sram_we   = accept;
   assign bus.sram_addr = wbin_q[ADDR-1:0];
   assign bus.sram_data = bus.wr_data;

   // Gray-to-binary conversion of the synchronised read pointer.
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rbin_s[i] = ^(rq2_q >> i);
      end
   end

   // Next-state pointers and flags, all derived from post-write values.
   always_comb begin
      wbin_d   = wbin_q + PW'(accept);
      wg_d     = wbin_d ^ (wbin_d >> 1);
      full_cmp = {~rq2_q[ADDR:ADDR-1], rq2_q[ADDR-2:0]};
      full_d   = (wg_d == full_cmp);
      lvl_d    = wbin_d - rbin_s;
      af_d     = (lvl_d >= AF_T);
      ovf_d    = bus.wr_req & full_q;
   end

   // State registers and read-pointer synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q <= '0;
         wg_q   <= '0;
         rq1_q  <= '0;
         rq2_q  <= '0;
         full_q <= 1'b0;
         af_q   <= 1'b0;
         lvl_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wbin_q <= wbin_d;
         wg_q   <= wg_d;
         rq1_q  <= bus.rd_gptr;
         rq2_q  <= rq1_q;
         full_q <= full_d;
         af_q   <= af_d;
         lvl_q  <= lvl_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.wr_gptr     = wg_q;
   assign bus.full        = full_q;
   assign bus.almost_full = af_q;
   assign bus.wr_level    = lvl_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (ADDR=4, WIDTH=32, AF_THRESH=12).
module tb_async_fifo_wr_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   async_fifo_wr_ctrl_if #(.ADDR(4), .WIDTH(32)) bus ();

   async_fifo_wr_ctrl #(.ADDR(4), .WIDTH(32), .AF_THRESH(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 2 time units past it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [4:0] mw;
   logic [4:0] rb;
   logic [4:0] prev_g;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n       = 1'b1;
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'hDEAD_BEEF;
      bus.rd_gptr = 5'd0;
      #1 rst_n = 1'b0;

      // 1. Reset with wr_req held high
      tick();
      tick();
      chk("rst_we",    32'(bus.sram_we), 32'd0);
      chk("rst_gptr",  32'(bus.wr_gptr), 32'd0);
      chk("rst_full",  32'(bus.full), 32'd0);
      chk("rst_af",    32'(bus.almost_full), 32'd0);
      chk("rst_level", 32'(bus.wr_level), 32'd0);
      chk("rst_ovf",   32'(bus.overflow), 32'd0);

      rst_n = 1'b1;
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'hA000_0000;
      #1;
      chk("first_addr", 32'(bus.sram_addr), 32'd0);
      chk("first_we",   32'(bus.sram_we), 32'd1);
      chk("first_data", bus.sram_data, 32'hA000_0000);

      // 2./3. Fill with rd_gptr=0; almost_full at 12, full at 16
      for (int i = 0; i < 16; i++) begin
         bus.wr_data = 32'hA000_0000 + 32'(i);
         #1;
         chk("fill_addr", 32'(bus.sram_addr), 32'(i));
         chk("fill_we",   32'(bus.sram_we), 32'd1);
         tick();
         chk("fill_level", 32'(bus.wr_level), 32'(i + 1));
         chk("fill_af",    32'(bus.almost_full), ((i + 1) >= 12) ? 32'd1 : 32'd0);
         chk("fill_full",  32'(bus.full), ((i + 1) == 16) ? 32'd1 : 32'd0);
      end
      chk("full_gptr", 32'(bus.wr_gptr), 32'b11000);

      // 17th request is rejected
      bus.wr_data = 32'hBAD0_0017;
      #1;
      chk("ovf_we", 32'(bus.sram_we), 32'd0);
      tick();
      chk("ovf_pulse", 32'(bus.overflow), 32'd1);
      chk("ovf_gptr",  32'(bus.wr_gptr), 32'b11000);
      chk("ovf_level", 32'(bus.wr_level), 32'd16);
      bus.wr_req = 1'b0;
      tick();
      chk("ovf_clear", 32'(bus.overflow), 32'd0);

      // 4. Read pointer advances to 4: visible after exactly 3 edges
      bus.rd_gptr = 5'b00110;
      tick();
      chk("drain_e1_full",  32'(bus.full), 32'd1);
      chk("drain_e1_level", 32'(bus.wr_level), 32'd16);
      tick();
      chk("drain_e2_full",  32'(bus.full), 32'd1);
      chk("drain_e2_level", 32'(bus.wr_level), 32'd16);
      tick();
      chk("drain_e3_full",  32'(bus.full), 32'd0);
      chk("drain_e3_level", 32'(bus.wr_level), 32'd12);
      chk("drain_e3_af",    32'(bus.almost_full), 32'd1);

      // 5. Wrap: 40 writes with the reader 8 words behind
      mw = 5'd16;
      prev_g = bus.wr_gptr;
      bus.wr_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rb = mw - 5'd8;
         bus.rd_gptr = gray(rb);
         bus.wr_data = 32'hC000_0000 + 32'(i);
         #1;
         chk("wrap_addr", 32'(bus.sram_addr), 32'(mw[3:0]));
         chk("wrap_we",   32'(bus.sram_we), 32'd1);
         tick();
         mw = mw + 5'd1;
         chk("wrap_gptr",  32'(bus.wr_gptr), 32'(gray(mw)));
         chk("wrap_1bit",  32'($countones(bus.wr_gptr ^ prev_g)), 32'd1);
         chk("wrap_noovf", 32'(bus.overflow), 32'd0);
         chk("wrap_nofull", 32'(bus.full), 32'd0);
         prev_g = bus.wr_gptr;
      end
      bus.wr_req = 1'b0;
      rb = mw - 5'd8;
      bus.rd_gptr = gray(rb);
      tick();
      tick();
      tick();
      chk("wrap_level", 32'(bus.wr_level), 32'd8);
      chk("wrap_af",    32'(bus.almost_full), 32'd0);

      // 6. Reset mid-burst after 7 writes
      bus.wr_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.wr_data = 32'hE000_0000 + 32'(i);
         tick();
      end
      chk("pre_rst_level", 32'(bus.wr_level), 32'd15);
      chk("pre_rst_af",    32'(bus.almost_full), 32'd1);
      rst_n = 1'b0;
      bus.rd_gptr = 5'd0;
      #1;
      chk("mid_rst_we",    32'(bus.sram_we), 32'd0);
      chk("mid_rst_gptr",  32'(bus.wr_gptr), 32'd0);
      chk("mid_rst_level", 32'(bus.wr_level), 32'd0);
      chk("mid_rst_af",    32'(bus.almost_full), 32'd0);
      chk("mid_rst_full",  32'(bus.full), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("restart_addr", 32'(bus.sram_addr), 32'd0);
      chk("restart_we",   32'(bus.sram_we), 32'd1);
      tick();
      chk("restart_gptr",  32'(bus.wr_gptr), 32'b00001);
      chk("restart_level", 32'(bus.wr_level), 32'd1);
      bus.wr_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
